// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: ID decode, ID/EX -> EX/MEM -> MEM/WB control pipeline, hazard stall and halt-drain FSM.
// Define PIPE_CTRL_BRANCH_EN to add branch/jump decode, the flush input and the jump/branch outputs.
module pipe_ctrl_unit #(
  parameter int REG_AW       = 5,
  parameter int XLEN         = 32,
  parameter int HALT_CODE    = 10,
  parameter int HALT_REG     = 17,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [6:0]        id_opcode,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [XLEN-1:0]   id_a7,
`ifdef PIPE_CTRL_BRANCH_EN
  input  logic              flush,
  output logic              ex_is_jal,
  output logic              ex_is_jalr,
  output logic              ex_branch,
  output logic              wb_pc_to_reg,
`endif
  output logic              stall,
  output logic              ex_alu_src,
  output logic [REG_AW-1:0] ex_rd,
  output logic              mem_mem_read,
  output logic              mem_mem_write,
  output logic [REG_AW-1:0] mem_rd,
  output logic              wb_mem_to_reg,
  output logic              wb_reg_write,
  output logic [REG_AW-1:0] wb_rd,
  output logic              is_halted
);

  localparam logic [6:0] OP_ARITH     = 7'b0110011;
  localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
  localparam logic [6:0] OP_LOAD      = 7'b0000011;
  localparam logic [6:0] OP_STORE     = 7'b0100011;
  localparam logic [6:0] OP_ECALL     = 7'b1110011;
`ifdef PIPE_CTRL_BRANCH_EN
  localparam logic [6:0] OP_BRANCH    = 7'b1100011;
  localparam logic [6:0] OP_JAL       = 7'b1101111;
  localparam logic [6:0] OP_JALR      = 7'b1100111;
`endif

  localparam logic [REG_AW-1:0] HALT_RD    = REG_AW'(HALT_REG);
  localparam logic [XLEN-1:0]   HALT_A7    = XLEN'(HALT_CODE);
  localparam logic [3:0]        DRAIN_LOAD = 4'(DRAIN_CYCLES);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic dec_alu_src, dec_mem_read, dec_mem_write, dec_mem_to_reg, dec_reg_write;
  logic dec_is_ecall, dec_uses_rs1, dec_uses_rs2;
  logic dec_branch, dec_is_jal, dec_is_jalr, dec_pc_to_reg;

  logic              idex_alu_src_q, idex_mem_read_q, idex_mem_write_q, idex_mem_to_reg_q;
  logic              idex_reg_write_q, idex_branch_q, idex_is_jal_q, idex_is_jalr_q, idex_pc_to_reg_q;
  logic [REG_AW-1:0] idex_rd_q;
  logic              idex_alu_src_d, idex_mem_read_d, idex_mem_write_d, idex_mem_to_reg_d;
  logic              idex_reg_write_d, idex_branch_d, idex_is_jal_d, idex_is_jalr_d, idex_pc_to_reg_d;
  logic [REG_AW-1:0] idex_rd_d;

  logic              exmem_mem_read_q, exmem_mem_write_q, exmem_mem_to_reg_q;
  logic              exmem_reg_write_q, exmem_pc_to_reg_q;
  logic [REG_AW-1:0] exmem_rd_q;

  logic              memwb_mem_to_reg_q, memwb_reg_write_q, memwb_pc_to_reg_q;
  logic [REG_AW-1:0] memwb_rd_q;

  logic flush_w, load_use, a7_pending, ecall_hz, hazard, halt_req, bubble;

`ifdef PIPE_CTRL_BRANCH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  // ID stage: opcode decode
  always_comb begin
    dec_alu_src    = 1'b0;
    dec_mem_read   = 1'b0;
    dec_mem_write  = 1'b0;
    dec_mem_to_reg = 1'b0;
    dec_reg_write  = 1'b0;
    dec_is_ecall   = 1'b0;
    dec_uses_rs1   = 1'b0;
    dec_uses_rs2   = 1'b0;
    dec_branch     = 1'b0;
    dec_is_jal     = 1'b0;
    dec_is_jalr    = 1'b0;
    dec_pc_to_reg  = 1'b0;
    case (id_opcode)
      OP_ARITH: begin
        dec_reg_write = 1'b1;
        dec_uses_rs1  = 1'b1;
        dec_uses_rs2  = 1'b1;
      end
      OP_ARITH_IMM: begin
        dec_alu_src   = 1'b1;
        dec_reg_write = 1'b1;
        dec_uses_rs1  = 1'b1;
      end
      OP_LOAD: begin
        dec_mem_read   = 1'b1;
        dec_mem_to_reg = 1'b1;
        dec_reg_write  = 1'b1;
        dec_alu_src    = 1'b1;
        dec_uses_rs1   = 1'b1;
      end
      OP_STORE: begin
        dec_mem_write = 1'b1;
        dec_alu_src   = 1'b1;
        dec_uses_rs1  = 1'b1;
        dec_uses_rs2  = 1'b1;
      end
      OP_ECALL: dec_is_ecall = 1'b1;
`ifdef PIPE_CTRL_BRANCH_EN
      OP_BRANCH: dec_branch = 1'b1;
      OP_JAL: begin
        dec_is_jal    = 1'b1;
        dec_reg_write = 1'b1;
        dec_pc_to_reg = 1'b1;
      end
      OP_JALR: begin
        dec_is_jalr   = 1'b1;
        dec_reg_write = 1'b1;
        dec_pc_to_reg = 1'b1;
        dec_alu_src   = 1'b1;
      end
`endif
      default: ;
    endcase
    // x0 is hard-wired, so a write to it is never a real write
    if (id_rd == '0) dec_reg_write = 1'b0;
  end

  assign load_use   = idex_mem_read_q && (idex_rd_q != '0) &&
                      ((dec_uses_rs1 && (idex_rd_q == id_rs1)) ||
                       (dec_uses_rs2 && (idex_rd_q == id_rs2)));
  // a7 has no forwarding path into ID, so ecall waits until the writer reaches WB
  assign a7_pending = (idex_reg_write_q && (idex_rd_q == HALT_RD)) ||
                      (exmem_reg_write_q && (exmem_rd_q == HALT_RD));
  assign ecall_hz   = dec_is_ecall && a7_pending;
  assign hazard     = load_use || ecall_hz;
  assign halt_req   = dec_is_ecall && !hazard && (id_a7 == HALT_A7) && !flush_w;

  assign stall      = hazard || (state_q != RUN);
  assign is_halted  = (state_q == HALTED);
  assign bubble     = stall || flush_w;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (halt_req) begin
          state_d = DRAIN;
          cnt_d   = DRAIN_LOAD;
        end
      end
      DRAIN: begin
        if (cnt_q == 4'd1) begin
          state_d = HALTED;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HALTED: ;
      default: begin
        state_d = RUN;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_comb begin
    idex_alu_src_d    = 1'b0;
    idex_mem_read_d   = 1'b0;
    idex_mem_write_d  = 1'b0;
    idex_mem_to_reg_d = 1'b0;
    idex_reg_write_d  = 1'b0;
    idex_branch_d     = 1'b0;
    idex_is_jal_d     = 1'b0;
    idex_is_jalr_d    = 1'b0;
    idex_pc_to_reg_d  = 1'b0;
    idex_rd_d         = '0;
    if (!bubble) begin
      idex_alu_src_d    = dec_alu_src;
      idex_mem_read_d   = dec_mem_read;
      idex_mem_write_d  = dec_mem_write;
      idex_mem_to_reg_d = dec_mem_to_reg;
      idex_reg_write_d  = dec_reg_write;
      idex_branch_d     = dec_branch;
      idex_is_jal_d     = dec_is_jal;
      idex_is_jalr_d    = dec_is_jalr;
      idex_pc_to_reg_d  = dec_pc_to_reg;
      idex_rd_d         = id_rd;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ID/EX boundary
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idex_alu_src_q    <= 1'b0;
      idex_mem_read_q   <= 1'b0;
      idex_mem_write_q  <= 1'b0;
      idex_mem_to_reg_q <= 1'b0;
      idex_reg_write_q  <= 1'b0;
      idex_branch_q     <= 1'b0;
      idex_is_jal_q     <= 1'b0;
      idex_is_jalr_q    <= 1'b0;
      idex_pc_to_reg_q  <= 1'b0;
      idex_rd_q         <= '0;
    end else begin
      idex_alu_src_q    <= idex_alu_src_d;
      idex_mem_read_q   <= idex_mem_read_d;
      idex_mem_write_q  <= idex_mem_write_d;
      idex_mem_to_reg_q <= idex_mem_to_reg_d;
      idex_reg_write_q  <= idex_reg_write_d;
      idex_branch_q     <= idex_branch_d;
      idex_is_jal_q     <= idex_is_jal_d;
      idex_is_jalr_q    <= idex_is_jalr_d;
      idex_pc_to_reg_q  <= idex_pc_to_reg_d;
      idex_rd_q         <= idex_rd_d;
    end
  end

  // EX/MEM boundary
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exmem_mem_read_q   <= 1'b0;
      exmem_mem_write_q  <= 1'b0;
      exmem_mem_to_reg_q <= 1'b0;
      exmem_reg_write_q  <= 1'b0;
      exmem_pc_to_reg_q  <= 1'b0;
      exmem_rd_q         <= '0;
    end else begin
      exmem_mem_read_q   <= idex_mem_read_q;
      exmem_mem_write_q  <= idex_mem_write_q;
      exmem_mem_to_reg_q <= idex_mem_to_reg_q;
      exmem_reg_write_q  <= idex_reg_write_q;
      exmem_pc_to_reg_q  <= idex_pc_to_reg_q;
      exmem_rd_q         <= idex_rd_q;
    end
  end

  // MEM/WB boundary
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      memwb_mem_to_reg_q <= 1'b0;
      memwb_reg_write_q  <= 1'b0;
      memwb_pc_to_reg_q  <= 1'b0;
      memwb_rd_q         <= '0;
    end else begin
      memwb_mem_to_reg_q <= exmem_mem_to_reg_q;
      memwb_reg_write_q  <= exmem_reg_write_q;
      memwb_pc_to_reg_q  <= exmem_pc_to_reg_q;
      memwb_rd_q         <= exmem_rd_q;
    end
  end

  assign ex_alu_src    = idex_alu_src_q;
  assign ex_rd         = idex_rd_q;
  assign mem_mem_read  = exmem_mem_read_q;
  assign mem_mem_write = exmem_mem_write_q;
  assign mem_rd        = exmem_rd_q;
  assign wb_mem_to_reg = memwb_mem_to_reg_q;
  assign wb_reg_write  = memwb_reg_write_q;
  assign wb_rd         = memwb_rd_q;

`ifdef PIPE_CTRL_BRANCH_EN
  assign ex_is_jal    = idex_is_jal_q;
  assign ex_is_jalr   = idex_is_jalr_q;
  assign ex_branch    = idex_branch_q;
  assign wb_pc_to_reg = memwb_pc_to_reg_q;
`else
  // Without branch support these fields stay constant zero and have no consumer.
  logic unused_branch;
  assign unused_branch = idex_branch_q | idex_is_jal_q | idex_is_jalr_q | memwb_pc_to_reg_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Self-checking bench for pipe_ctrl_unit: directed scenarios plus random instruction streams
// compared against an instruction-history reference model.
`timescale 1ns/1ps
module tb_pipe_ctrl_unit;
  localparam int DRAIN = 3;
  localparam logic [6:0] ARITH = 7'b0110011, ARITH_IMM = 7'b0010011, LOAD = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011, ECALL = 7'b1110011, BRANCH = 7'b1100011;
  localparam logic [6:0] JAL = 7'b1101111, JALR = 7'b1100111, NOP = 7'b0000000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  id_opcode = '0;
  logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic [31:0] id_a7 = '0;
  logic        stall, ex_alu_src, mem_mem_read, mem_mem_write, wb_mem_to_reg, wb_reg_write, is_halted;
  logic [4:0]  ex_rd, mem_rd, wb_rd;
`ifdef PIPE_CTRL_BRANCH_EN
  logic        flush = 1'b0;
  logic        ex_is_jal, ex_is_jalr, ex_branch, wb_pc_to_reg;
`endif

  always #5 clk = ~clk;

  pipe_ctrl_unit dut (
    .clk(clk), .reset(reset), .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_a7(id_a7),
`ifdef PIPE_CTRL_BRANCH_EN
    .flush(flush), .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr), .ex_branch(ex_branch),
    .wb_pc_to_reg(wb_pc_to_reg),
`endif
    .stall(stall), .ex_alu_src(ex_alu_src), .ex_rd(ex_rd), .mem_mem_read(mem_mem_read),
    .mem_mem_write(mem_mem_write), .mem_rd(mem_rd), .wb_mem_to_reg(wb_mem_to_reg),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .is_halted(is_halted)
  );

  typedef struct packed {
    logic alu_src, mem_read, mem_write, mem_to_reg, reg_write;
    logic branch, is_jal, is_jalr, pc_to_reg;
    logic [4:0] rd;
  } rec_t;

  rec_t pipe_hist[$];   // [0] = last instruction to enter EX, [1] MEM, [2] WB
  int   cyc;
  int   halt_edge;
  int   n_tests = 0;
  int   n_fail = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic rec_t model_dec(input logic [6:0] op, input logic [4:0] rd);
    rec_t r = '0;
    case (op)
      ARITH:     r.reg_write = 1'b1;
      ARITH_IMM: begin r.alu_src = 1'b1; r.reg_write = 1'b1; end
      LOAD:      begin r.mem_read = 1'b1; r.mem_to_reg = 1'b1; r.reg_write = 1'b1; r.alu_src = 1'b1; end
      STORE:     begin r.mem_write = 1'b1; r.alu_src = 1'b1; end
`ifdef PIPE_CTRL_BRANCH_EN
      BRANCH:    r.branch = 1'b1;
      JAL:       begin r.is_jal = 1'b1; r.reg_write = 1'b1; r.pc_to_reg = 1'b1; end
      JALR:      begin r.is_jalr = 1'b1; r.reg_write = 1'b1; r.pc_to_reg = 1'b1; r.alu_src = 1'b1; end
`endif
      default: ;
    endcase
    if (rd == 5'd0) r.reg_write = 1'b0;
    r.rd = rd;
    return r;
  endfunction

  function automatic bit reads_rs1(input logic [6:0] op);
    return (op == ARITH) || (op == ARITH_IMM) || (op == LOAD) || (op == STORE);
  endfunction

  function automatic bit reads_rs2(input logic [6:0] op);
    return (op == ARITH) || (op == STORE);
  endfunction

  task automatic model_reset();
    pipe_hist = {};
    repeat (3) pipe_hist.push_back('0);
    cyc = 0;
    halt_edge = -1;
  endtask

  // Starts and ends at a negative clock edge; one instruction presented to ID per call.
  task automatic step(input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2,
                      input logic [4:0] rd, input logic [31:0] a7, input bit fl, output bit stalled);
    rec_t d, e, m, w;
    bit   f, lu, ehz, hz, halting, halted, exp_stall;
    f = 1'b0;
`ifdef PIPE_CTRL_BRANCH_EN
    f = fl;
    flush = fl;
`endif
    id_opcode = op; id_rs1 = r1; id_rs2 = r2; id_rd = rd; id_a7 = a7;
    #1;
    d = model_dec(op, rd);
    e = pipe_hist[0]; m = pipe_hist[1]; w = pipe_hist[2];
    lu  = e.mem_read && (e.rd != 0) &&
          ((reads_rs1(op) && e.rd == r1) || (reads_rs2(op) && e.rd == r2));
    ehz = (op == ECALL) && ((e.reg_write && e.rd == 5'd17) || (m.reg_write && m.rd == 5'd17));
    hz  = lu || ehz;
    halting   = (halt_edge >= 0);
    halted    = halting && (cyc >= halt_edge + DRAIN);
    exp_stall = hz || halting;
    check_val("stall", stall, exp_stall);
    check_val("ex_alu_src", ex_alu_src, e.alu_src);
    check_val("ex_rd", ex_rd, e.rd);
    check_val("mem_mem_read", mem_mem_read, m.mem_read);
    check_val("mem_mem_write", mem_mem_write, m.mem_write);
    check_val("mem_rd", mem_rd, m.rd);
    check_val("wb_mem_to_reg", wb_mem_to_reg, w.mem_to_reg);
    check_val("wb_reg_write", wb_reg_write, w.reg_write);
    check_val("wb_rd", wb_rd, w.rd);
    check_val("is_halted", is_halted, halted);
`ifdef PIPE_CTRL_BRANCH_EN
    check_val("ex_is_jal", ex_is_jal, e.is_jal);
    check_val("ex_is_jalr", ex_is_jalr, e.is_jalr);
    check_val("ex_branch", ex_branch, e.branch);
    check_val("wb_pc_to_reg", wb_pc_to_reg, w.pc_to_reg);
`endif
    @(posedge clk);
    cyc++;
    pipe_hist.push_front((exp_stall || f) ? rec_t'('0) : d);
    void'(pipe_hist.pop_back());
    if (!halting && op == ECALL && !hz && a7 == 32'd10 && !f) halt_edge = cyc;
    stalled = exp_stall;
    @(negedge clk);
  endtask

  // Holds the instruction in ID while the model predicts a stall, as IF/ID would.
  task automatic issue(input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rd, input logic [31:0] a7, input bit fl, output int stalls);
    bit s;
    stalls = 0;
    s = 1'b1;
    for (int i = 0; i < 8 && s; i++) begin
      step(op, r1, r2, rd, a7, fl, s);
      if (s) stalls++;
    end
    if (s) check_val("issue_bound", s, 1'b0);
  endtask

  task automatic idle(input int n);
    bit s;
    for (int i = 0; i < n; i++) step(NOP, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, s);
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    check_val("rst_stall", stall, 1'b0);
    check_val("rst_ex_rd", ex_rd, 5'd0);
    check_val("rst_ex_alu_src", ex_alu_src, 1'b0);
    check_val("rst_mem_read", mem_mem_read, 1'b0);
    check_val("rst_mem_rd", mem_rd, 5'd0);
    check_val("rst_wb_reg_write", wb_reg_write, 1'b0);
    check_val("rst_wb_rd", wb_rd, 5'd0);
    check_val("rst_is_halted", is_halted, 1'b0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  logic [6:0] op_tab [10];

  initial begin
    int  st, n;
    bit  s;
    model_reset();
    @(negedge clk);
    do_reset();

    // Async reset with ADD in flight, then a fresh ADD rd=5
    issue(ARITH, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0, st);
    issue(ARITH, 5'd1, 5'd2, 5'd4, 32'd0, 1'b0, st);
    do_reset();
    issue(ARITH, 5'd1, 5'd2, 5'd5, 32'd0, 1'b0, st);
    check_val("add_ex_rd", ex_rd, 5'd5);
    idle(2);
    check_val("add_wb_reg_write", wb_reg_write, 1'b1);
    check_val("add_wb_rd", wb_rd, 5'd5);

    // Load-use: exactly one stall, bubble visible in MEM
    issue(LOAD, 5'd1, 5'd0, 5'd6, 32'd0, 1'b0, st);
    issue(ARITH, 5'd6, 5'd2, 5'd7, 32'd0, 1'b0, st);
    check_val("lu_stalls", st, 1);
    check_val("lu_bubble_mem_read", mem_mem_read, 1'b0);

    // Load to x0 never hazards and never writes back
    issue(LOAD, 5'd1, 5'd0, 5'd0, 32'd0, 1'b0, st);
    issue(ARITH, 5'd0, 5'd2, 5'd8, 32'd0, 1'b0, st);
    check_val("ld_x0_stalls", st, 0);
    idle(1);
    check_val("ld_x0_wb_reg_write", wb_reg_write, 1'b0);

    // Non-halting ecall behaves as a no-op
    issue(ECALL, 5'd0, 5'd0, 5'd0, 32'd4, 1'b0, st);
    check_val("ecall4_stalls", st, 0);
    issue(ARITH, 5'd1, 5'd2, 5'd9, 32'd0, 1'b0, st);
    check_val("ecall4_add_stalls", st, 0);
    idle(2);
    check_val("ecall4_wb_rd", wb_rd, 5'd9);
    check_val("ecall4_not_halted", is_halted, 1'b0);

    // a7 written just ahead of a halting ecall
    issue(ARITH_IMM, 5'd0, 5'd0, 5'd17, 32'd0, 1'b0, st);
    issue(ECALL, 5'd0, 5'd0, 5'd0, 32'd10, 1'b0, st);
    check_val("ecall_hz_stalls", st, 2);
    n = 0;
    while (!is_halted && n < 10) begin
      step(NOP, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, s);
      n++;
    end
    check_val("halt_latency", n, DRAIN);
    idle(3);
    check_val("halt_sticky", is_halted, 1'b1);
    do_reset();

`ifdef PIPE_CTRL_BRANCH_EN
    issue(JAL, 5'd0, 5'd0, 5'd1, 32'd0, 1'b0, st);
    check_val("jal_ex_is_jal", ex_is_jal, 1'b1);
    idle(2);
    check_val("jal_wb_pc_to_reg", wb_pc_to_reg, 1'b1);
    check_val("jal_wb_reg_write", wb_reg_write, 1'b1);
    issue(JAL, 5'd0, 5'd0, 5'd1, 32'd0, 1'b1, st);
    check_val("jal_flush_ex_is_jal", ex_is_jal, 1'b0);
    check_val("jal_flush_ex_rd", ex_rd, 5'd0);
    check_val("jal_flush_ex_alu_src", ex_alu_src, 1'b0);
    issue(ECALL, 5'd0, 5'd0, 5'd0, 32'd10, 1'b1, st);
    idle(4);
    check_val("flushed_ecall_no_halt", is_halted, 1'b0);
`endif

    // Random instruction streams
    op_tab = '{ARITH, ARITH_IMM, LOAD, STORE, ECALL, BRANCH, JAL, JALR, NOP, 7'h7f};
    for (int i = 0; i < 1500; i++) begin
      logic [6:0]  op;
      logic [4:0]  r1, r2, rd;
      logic [31:0] a7;
      bit          fl;
      if (halt_edge >= 0) begin
        idle(DRAIN + 2);
        do_reset();
      end else if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end
      op = op_tab[$urandom_range(0, 9)];
      r1 = ($urandom_range(0, 5) == 0) ? 5'd17 : 5'($urandom_range(0, 7));
      r2 = 5'($urandom_range(0, 7));
      rd = ($urandom_range(0, 3) == 0) ? 5'd17 : 5'($urandom_range(0, 7));
      a7 = ($urandom_range(0, 3) == 0) ? 32'd10 : $urandom;
      fl = ($urandom_range(0, 9) == 0);
      issue(op, r1, r2, rd, a7, fl, st);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
- Parametrised successor to the single-stage pipeline decoder.
- Decodes the ID-stage opcode into a control bundle and carries it through internal ID/EX, EX/MEM and MEM/WB control registers.
- Detects load-use and ecall-operand hazards and generates stall.
- Runs a halt FSM that drains the pipeline after a terminating ecall.
- Sits beside the 5-stage datapath; the datapath pipeline registers carry data only.

Parameters:
- REG_AW, 5, register-address width.
- XLEN, 32, width of the ecall argument input.
- HALT_CODE, 10, a7 value that makes ecall terminate.
- HALT_REG, 17, register index holding the ecall argument.
- DRAIN_CYCLES, 3, cycles waited after a halting ecall before is_halted is raised (range 1..15).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- id_opcode  in  7  opcode of the instruction in ID.
- id_rs1  in  REG_AW  ID source register 1.
- id_rs2  in  REG_AW  ID source register 2.
- id_rd  in  REG_AW  ID destination register.
- id_a7  in  XLEN  register-file read of HALT_REG.
- stall  out  1  hold PC and IF/ID; bubble into ID/EX.
- ex_alu_src  out  1  registered control, EX stage.
- ex_rd  out  REG_AW  registered destination, EX stage.
- mem_mem_read  out  1  registered control, MEM stage.
- mem_mem_write  out  1  registered control, MEM stage.
- mem_rd  out  REG_AW  registered destination, MEM stage.
- wb_mem_to_reg  out  1  registered control, WB stage.
- wb_reg_write  out  1  registered control, WB stage.
- wb_rd  out  REG_AW  registered destination, WB stage.
- is_halted  out  1  sticky halt flag.

Behaviour:
- Decode (combinational, ID):
  - ARITHMETIC 0110011: reg_write.
  - ARITHMETIC_IMM 0010011: alu_src, reg_write.
  - LOAD 0000011: mem_read, mem_to_reg, reg_write, alu_src.
  - STORE 0100011: mem_write, alu_src.
  - ECALL 1110011: is_ecall.
  - Any other opcode: all zero.
- reg_write is forced to 0 when id_rd == 0.
- Reset (async, active-high): all stage registers cleared (bubble); all rd fields = 0; stall = 0; is_halted = 0; FSM = RUN; drain counter = 0. Reset mid-drain aborts the drain.
- Stage advance, every clk edge when not in reset:
  - ID/EX <= decoded bundle, or bubble (all zero) if stall.
  - EX/MEM <= ID/EX.
  - MEM/WB <= EX/MEM.
  - Downstream stages are never frozen.
- Latency: decoded bit appears on ex_* 1 cycle later, mem_* 2 cycles later, wb_* 3 cycles later.
- Load-use hazard:
  - Triggers when ID/EX.mem_read == 1, ID/EX.rd != 0, and ID/EX.rd matches id_rs1 (ARITH/ARITH_IMM/LOAD/STORE) or id_rs2 (ARITH/STORE).
  - Produces exactly 1 stall cycle.
- Ecall hazard:
  - ID holds ECALL and HALT_REG is being written in ID/EX or EX/MEM (reg_write == 1, rd == HALT_REG).
  - Stall until neither condition holds; no ecall forwarding.
- Halt FSM, states RUN -> DRAIN -> HALTED:
  - RUN -> DRAIN when ID holds ECALL, no hazard, and id_a7 == HALT_CODE. Load counter = DRAIN_CYCLES; the ecall itself enters ID/EX.
  - DRAIN: stall = 1; decrement each cycle. At counter == 1 -> HALTED.
  - HALTED: stall = 1, is_halted = 1; holds until reset.
  - Ecall with id_a7 != HALT_CODE passes as a no-op; FSM stays in RUN.
- Simultaneous events: a hazard and a halting ecall in the same cycle -> the hazard wins; the ecall is re-evaluated after the stall clears.

Optional Feature:
- Macro: PIPE_CTRL_BRANCH_EN.
- When defined:
  - Adds input flush (1) and outputs ex_is_jal, ex_is_jalr, ex_branch, wb_pc_to_reg.
  - Decode adds BRANCH 1100011 -> branch; JAL 1101111 -> is_jal, reg_write, pc_to_reg; JALR 1100111 -> is_jalr, reg_write, pc_to_reg, alu_src.
  - flush = 1 bubbles ID/EX in that cycle, with priority over stall.
  - flush does not affect the halt FSM unless the flushed instruction is the ecall: in RUN, flush suppresses the RUN -> DRAIN transition.
- When undefined:
  - Those ports are absent.
  - Branch and jump opcodes decode to all-zero.

Test Plan:
- Reset asserted mid-run with ADD in flight -> all outputs 0 immediately (async); first ADD after release (rd = 5) gives ex_rd = 5 at +1, wb_reg_write = 1 and wb_rd = 5 at +3.
- LOAD rd = 6, then ADD rs1 = 6 -> stall = 1 for exactly 1 cycle; ID/EX bubble gives mem_mem_read = 0 in the following cycle.
- LOAD rd = 0, then ADD rs1 = 0 -> no stall; wb_reg_write = 0 for the load.
- ADDI rd = 17, then ECALL with id_a7 = 10 -> stall for 2 cycles, then DRAIN; is_halted = 1 exactly DRAIN_CYCLES = 3 cycles after the ecall leaves ID, and stays high.
- ECALL with id_a7 = 4 -> no stall, is_halted stays 0; the next ADD flows normally.
- With PIPE_CTRL_BRANCH_EN defined: JAL rd = 1 -> ex_is_jal = 1, wb_pc_to_reg = 1 and wb_reg_write = 1 at +3; the same JAL with flush = 1 -> all ex_* outputs 0.
